// File: rtl/bit_serializer.sv
// bit_serializer: valid/ready parallel-to-serial shifter with bit stall, optional inter-word gap and selectable bit order
module bit_serializer #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             en,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             word_done
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [CW-1:0] bit_cnt, bit_cnt_nx;
  logic [3:0] gap_cnt, gap_cnt_nx;
  logic last, fin, shift, load;
  always_comb begin
    last = bit_cnt == CW'(WIDTH - 1);
    fin = state == SHIFT && en && last;
    shift = state == SHIFT && en && !last;
    din_ready = !rst && (state == IDLE || (fin && GAP_CYCLES == 0));
    load = din_valid && din_ready;
    sout_valid = state == SHIFT;
    sout = state == SHIFT && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
    busy = state != IDLE;
    shreg_nx = load ? din : shift ? (MSB_FIRST ? shreg << 1 : shreg >> 1) : shreg;
    bit_cnt_nx = load ? '0 : shift ? bit_cnt + 1'b1 : bit_cnt;
    gap_cnt_nx = (fin && GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) :
                 (state == GAP && gap_cnt != 0) ? gap_cnt - 1'b1 : gap_cnt;
    state_nx = state == IDLE  ? (load ? SHIFT : IDLE) :
               state == SHIFT ? (!fin ? SHIFT : GAP_CYCLES > 0 ? GAP : load ? SHIFT : IDLE) :
               (gap_cnt == 0 ? IDLE : GAP);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      word_done <= 1'b0;
    end else begin
      state <= state_nx;
      shreg <= shreg_nx;
      bit_cnt <= bit_cnt_nx;
      gap_cnt <= gap_cnt_nx;
      word_done <= fin;
    end
  end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: table-driven check of three bit_serializer configurations (default, GAP_CYCLES=2, LSB-first)
module tb_bit_serializer;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] din [3];
  logic [2:0] dv, en, sout, sv, rdy, busy, wd;
  int n_vec = 0;
  int n_err = 0;
  typedef struct {
    int d;
    logic v;
    logic [7:0] x;
    logic e;
    logic [4:0] exp;
  } vec_t;
  vec_t vecs[$];
  always #5 clk = ~clk;
  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u_a (
    .clk(clk), .rst(rst), .din(din[0]), .din_valid(dv[0]), .din_ready(rdy[0]), .en(en[0]),
    .sout(sout[0]), .sout_valid(sv[0]), .busy(busy[0]), .word_done(wd[0]));
  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) u_b (
    .clk(clk), .rst(rst), .din(din[1]), .din_valid(dv[1]), .din_ready(rdy[1]), .en(en[1]),
    .sout(sout[1]), .sout_valid(sv[1]), .busy(busy[1]), .word_done(wd[1]));
  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) u_c (
    .clk(clk), .rst(rst), .din(din[2]), .din_valid(dv[2]), .din_ready(rdy[2]), .en(en[2]),
    .sout(sout[2]), .sout_valid(sv[2]), .busy(busy[2]), .word_done(wd[2]));
  function automatic logic [4:0] obs(int d);
    return {sout[d], sv[d], rdy[d], busy[d], wd[d]};
  endfunction
  task automatic chk(string nm, logic [4:0] act, logic [4:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s {sout,sv,rdy,busy,wd} got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic add(int d, logic v, logic [7:0] x, logic e, logic so, logic vo, logic rd, logic bz, logic dn);
    vec_t r;
    r.d = d;
    r.v = v;
    r.x = x;
    r.e = e;
    r.exp = {so, vo, rd, bz, dn};
    vecs.push_back(r);
  endtask
  task automatic run_table(string tag);
    foreach (vecs[i]) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        dv[k] = 1'b0;
        en[k] = 1'b1;
      end
      dv[vecs[i].d] = vecs[i].v;
      din[vecs[i].d] = vecs[i].x;
      en[vecs[i].d] = vecs[i].e;
      #1;
      chk($sformatf("%s[%0d]", tag, i), obs(vecs[i].d), vecs[i].exp);
    end
    vecs.delete();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    logic [7:0] w;
    logic [15:0] s;
    logic [10:0] en_p, so_p;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din[k] = 8'hFF;
      dv[k] = 1'b1;
      en[k] = 1'b1;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      for (int k = 0; k < 3; k++) chk($sformatf("reset%0d.dut%0d", c, k), obs(k), 5'b00000);
    end
    @(negedge clk);
    rst = 1'b0;
    dv = '0;
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("release.dut%0d", k), obs(k), 5'b00100);
    w = 8'hD5;
    add(0, 1, 8'hD5, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 0, 8'h00, 1, w[7-i], 1, i == 7, 1, 0);
    add(0, 0, 8'h00, 1, 0, 0, 1, 0, 1);
    add(0, 0, 8'h00, 1, 0, 0, 1, 0, 0);
    run_table("single");
    s = 16'hD5A3;
    add(0, 1, 8'hD5, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 16; i++) add(0, i <= 7, 8'hA3, 1, s[15-i], 1, i == 7 || i == 15, 1, i == 8);
    add(0, 0, 8'h00, 1, 0, 0, 1, 0, 1);
    add(0, 0, 8'h00, 1, 0, 0, 1, 0, 0);
    run_table("b2b");
    w = 8'hA3;
    add(1, 1, 8'hD5, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) add(1, 1, 8'hA3, 1, s[15-i], 1, 0, 1, 0);
    add(1, 1, 8'hA3, 1, 0, 0, 0, 1, 1);
    add(1, 1, 8'hA3, 1, 0, 0, 0, 1, 0);
    add(1, 1, 8'hA3, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) add(1, 0, 8'h00, 1, w[7-i], 1, 0, 1, 0);
    add(1, 0, 8'h00, 1, 0, 0, 0, 1, 1);
    add(1, 0, 8'h00, 1, 0, 0, 0, 1, 0);
    add(1, 0, 8'h00, 1, 0, 0, 1, 0, 0);
    run_table("gap");
    en_p = 11'b110_0011_1111;
    so_p = 11'b110_0001_0000;
    add(2, 1, 8'h0B, 1, 0, 0, 1, 0, 0);
    for (int j = 0; j < 11; j++) add(2, 0, 8'hFF, en_p[10-j], so_p[10-j], 1, j == 10, 1, 0);
    add(2, 0, 8'hFF, 1, 0, 0, 1, 0, 1);
    add(2, 0, 8'hFF, 1, 0, 0, 1, 0, 0);
    run_table("lsb_stall");
    add(0, 1, 8'hFF, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 8'h00, 1, 1, 1, 0, 1, 0);
    run_table("pre_abort");
    @(negedge clk);
    #1;
    chk("abort.bit4", obs(0), 5'b11010);
    #2;
    rst = 1'b1;
    #1;
    chk("abort.async", obs(0), 5'b00000);
    @(negedge clk);
    #1;
    chk("abort.held", obs(0), 5'b00000);
    rst = 1'b0;
    #1;
    chk("abort.release", obs(0), 5'b00100);
    w = 8'h81;
    add(0, 1, 8'h81, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 0, 8'h00, 1, w[7-i], 1, i == 7, 1, 0);
    add(0, 0, 8'h00, 1, 0, 0, 1, 0, 1);
    add(0, 0, 8'h00, 1, 0, 0, 1, 0, 0);
    run_table("after_abort");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
